// File: rtl/fft_frame_ctrl_if.sv
// Handshake bundle between the frame controller, the upstream source,
// the FFT core (config/data in/data out) and the downstream consumer.
interface fft_frame_ctrl_if #(
  parameter int unsigned DATAWIDTH = 48,
  parameter int unsigned CFG_WIDTH = 16
);
  // upstream samples
  logic [DATAWIDTH-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  // core config channel
  logic [CFG_WIDTH-1:0] cfg_tdata;
  logic                 cfg_tvalid;
  logic                 cfg_tready;
  // core data input
  logic [DATAWIDTH-1:0] fft_in_tdata;
  logic                 fft_in_tvalid;
  logic                 fft_in_tlast;
  logic                 fft_in_tready;
  // core data output
  logic [DATAWIDTH-1:0] fft_out_tdata;
  logic                 fft_out_tvalid;
  logic                 fft_out_tlast;
  logic                 fft_out_tready;
  // downstream results
  logic [DATAWIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_last;
  logic                 m_ready;

  // controller side
  modport master (
    input  s_data, s_valid,
    output s_ready,
    output cfg_tdata, cfg_tvalid,
    input  cfg_tready,
    output fft_in_tdata, fft_in_tvalid, fft_in_tlast,
    input  fft_in_tready,
    input  fft_out_tdata, fft_out_tvalid, fft_out_tlast,
    output fft_out_tready,
    output m_data, m_valid, m_last,
    input  m_ready
  );

  // source / core / sink side
  modport slave (
    output s_data, s_valid,
    input  s_ready,
    input  cfg_tdata, cfg_tvalid,
    output cfg_tready,
    input  fft_in_tdata, fft_in_tvalid, fft_in_tlast,
    output fft_in_tready,
    output fft_out_tdata, fft_out_tvalid, fft_out_tlast,
    input  fft_out_tready,
    input  m_data, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FFT core: config word, N-sample load with tlast,
// N-sample unload with counter-generated last and tlast alignment check.
module fft_frame_ctrl #(
  parameter int unsigned DATAWIDTH = 48,
  parameter int unsigned NFFT_LOG2 = 9,
  parameter int unsigned SCALE_W   = 10,
  parameter int unsigned CFG_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dir,
  input  logic [SCALE_W-1:0] scale_sch,
  fft_frame_ctrl_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        frame_count
);

  localparam int unsigned CNT_W = NFFT_LOG2;
  localparam int unsigned FC_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_LOAD,
    S_UNLOAD,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   in_cnt_q;
  logic [CNT_W-1:0]   out_cnt_q;
  logic               dir_q;
  logic [SCALE_W-1:0] scale_q;
  logic               cfg_tvalid_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [FC_W-1:0]    frame_count_q;

  logic in_load_c;
  logic in_unload_c;
  logic in_last_c;
  logic out_last_c;
  logic in_xfer_c;
  logic out_xfer_c;

  // Phase decode and transfer qualifiers; counters at all-ones mark the last sample.
  assign in_load_c   = (state_q == S_LOAD);
  assign in_unload_c = (state_q == S_UNLOAD);
  assign in_last_c   = &in_cnt_q;
  assign out_last_c  = &out_cnt_q;
  assign in_xfer_c   = in_load_c && bus.s_valid && bus.fft_in_tready;
  assign out_xfer_c  = in_unload_c && bus.fft_out_tvalid && bus.m_ready;

  // Zero-latency pass-through, gated so handshakes are only live in their phase.
  assign bus.fft_in_tdata   = DATAWIDTH'(bus.s_data);
  assign bus.fft_in_tvalid  = in_load_c && bus.s_valid;
  assign bus.fft_in_tlast   = in_load_c && in_last_c;
  assign bus.s_ready        = in_load_c && bus.fft_in_tready;
  assign bus.m_data         = DATAWIDTH'(bus.fft_out_tdata);
  assign bus.m_valid        = in_unload_c && bus.fft_out_tvalid;
  assign bus.m_last         = in_unload_c && out_last_c;
  assign bus.fft_out_tready = in_unload_c && bus.m_ready;

  // Config word built from latched fields, direction in bit 0.
  assign bus.cfg_tdata  = CFG_WIDTH'({scale_q, dir_q});
  assign bus.cfg_tvalid = cfg_tvalid_q;

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign frame_count = frame_count_q;

  // Frame sequencer: state, counters, latched config and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      dir_q         <= 1'b0;
      scale_q       <= '0;
      cfg_tvalid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_q        <= dir;
            scale_q      <= scale_sch;
            err_q        <= 1'b0;
            cfg_tvalid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          if (bus.cfg_tready) begin
            cfg_tvalid_q <= 1'b0;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_xfer_c) begin
            in_cnt_q <= in_cnt_q + CNT_W'(1);
            if (in_last_c) begin
              state_q <= S_UNLOAD;
            end
          end
        end
        S_UNLOAD: begin
          if (out_xfer_c) begin
            out_cnt_q <= out_cnt_q + CNT_W'(1);
            if (bus.fft_out_tlast != out_last_c) begin
              err_q <= 1'b1;
            end
            if (out_last_c) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          frame_count_q <= frame_count_q + FC_W'(1);
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
